// File: rtl/div_p3.sv
`default_nettype none
// ============================================================================
// Module   : div_p3
// Purpose  : Back end of the pipelined single-precision divider. Takes the
//            unpacked operands from the front-end stage, computes the mantissa
//            quotient with a 26-step restoring divider, then normalizes,
//            rounds and packs the IEEE-754 result.
// Ports    : clk, rst (async, active-low)
//            in_valid / in_ready      - operand handshake
//            sign, exp_diff, mant_a, mant_b - unpacked operands
//            out_valid / out_ready    - result handshake
//            result                   - packed IEEE-754 quotient
//            overflow / underflow / invalid - exception flags (one-hot or 0)
// Revision : 1.0 - initial release
// ============================================================================
module div_p3 #(
    parameter bit ROUND_RNE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign,
    input  logic [8:0]  exp_diff,
    input  logic [23:0] mant_a,
    input  logic [23:0] mant_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        invalid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [4:0] LAST_STEP = 5'd25;

    state_t      state;
    state_t      state_nxt;

    logic        sign_q;
    logic [8:0]  exp_q;
    logic [23:0] mb_q;
    logic [25:0] rem;
    logic [25:0] q;
    logic [4:0]  cnt;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = DIV;
            DIV:     if (cnt == LAST_STEP) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // ------------------------------------------------------------------
    // Restoring divider step. The extra top bit of the trial subtraction
    // is the borrow: clear means the remainder covered the divisor.
    // ------------------------------------------------------------------
    logic [26:0] trial;
    logic [25:0] diff;
    logic        fits;

    assign trial = {1'b0, rem} - {3'b000, mb_q};
    assign diff  = trial[25:0];
    assign fits  = ~trial[26];

    // ------------------------------------------------------------------
    // Normalize / round (combinational, consumed in ROUND)
    // ------------------------------------------------------------------
    logic signed [9:0] e_base;
    logic signed [9:0] e_norm;
    logic signed [9:0] e_rnd;
    logic [22:0]       frac_n;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [23:0]       frac_sum;

    // Exponent differences in the top quarter of the 9-bit range wrapped
    // around from below zero, so they are sign-extended as negatives.
    assign e_base = (exp_q[8:7] == 2'b11) ? signed'({1'b1, exp_q})
                                          : signed'({1'b0, exp_q});

    always_comb begin
        frac_n = q[23:1];
        guard  = q[0];
        sticky = (rem != 26'd0);
        e_norm = e_base - 10'sd1;
        if (q[25]) begin
            frac_n = q[24:2];
            guard  = q[1];
            sticky = q[0] | (rem != 26'd0);
            e_norm = e_base;
        end
    end

    assign round_up = ROUND_RNE & guard & (sticky | frac_n[0]);
    assign frac_sum = {1'b0, frac_n} + {23'd0, round_up};
    // A carry out of the fraction means the mantissa rounded up to 2.0;
    // the low 23 bits are already zero in that case.
    assign e_rnd    = e_norm + (frac_sum[23] ? 10'sd1 : 10'sd0);

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_q    <= 1'b0;
            exp_q     <= 9'd0;
            mb_q      <= 24'd0;
            rem       <= 26'd0;
            q         <= 26'd0;
            cnt       <= 5'd0;
            result    <= 32'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= sign;
                        exp_q  <= exp_diff;
                        mb_q   <= mant_b;
                        rem    <= {2'b00, mant_a};
                        q      <= 26'd0;
                        cnt    <= 5'd0;
                    end
                end
                DIV: begin
                    rem <= fits ? (diff << 1) : (rem << 1);
                    q   <= {q[24:0], fits};
                    cnt <= cnt + 5'd1;
                end
                ROUND: begin
                    overflow  <= 1'b0;
                    underflow <= 1'b0;
                    invalid   <= 1'b0;
                    if (mb_q == 24'd0) begin
                        result  <= 32'h7FC0_0000;
                        invalid <= 1'b1;
                    end else if (e_rnd >= 10'sd255) begin
                        result   <= {sign_q, 8'hFF, 23'd0};
                        overflow <= 1'b1;
                    end else if (e_rnd <= 10'sd0) begin
                        result    <= {sign_q, 31'd0};
                        underflow <= 1'b1;
                    end else begin
                        result <= {sign_q, e_rnd[7:0], frac_sum[22:0]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_p3.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_p3
// Purpose  : Self-checking bench for div_p3. Two instances share stimulus:
//            one rounding to nearest-even, one truncating. Expected results
//            come from an arithmetic reference model of the quotient.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_p3;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        sign;
    logic [8:0]  exp_diff;
    logic [23:0] mant_a;
    logic [23:0] mant_b;
    logic        out_ready;

    logic        in_ready_n,  in_ready_t;
    logic        out_valid_n, out_valid_t;
    logic [31:0] result_n,    result_t;
    logic        ovf_n, unf_n, inv_n;
    logic        ovf_t, unf_t, inv_t;

    int n_vec;
    int n_err;

    div_p3 #(.ROUND_RNE(1'b1)) dut_rne (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_n),
        .sign(sign), .exp_diff(exp_diff), .mant_a(mant_a), .mant_b(mant_b),
        .out_valid(out_valid_n), .out_ready(out_ready),
        .result(result_n),
        .overflow(ovf_n), .underflow(unf_n), .invalid(inv_n)
    );

    div_p3 #(.ROUND_RNE(1'b0)) dut_trn (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_t),
        .sign(sign), .exp_diff(exp_diff), .mant_a(mant_a), .mant_b(mant_b),
        .out_valid(out_valid_t), .out_ready(out_ready),
        .result(result_t),
        .overflow(ovf_t), .underflow(unf_t), .invalid(inv_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact quotient a/b scaled by 2^25, then rounded to 24 bits.
    function automatic void model(input logic s, input logic [8:0] ed,
                                  input logic [23:0] a, input logic [23:0] b,
                                  input bit rne,
                                  output logic [31:0] res, output logic [2:0] flg);
        longint num, qq, rr, frac;
        int     e;
        bit     g, st;
        if (b == 24'd0) begin
            res = 32'h7FC0_0000;
            flg = 3'b001;
            return;
        end
        num = longint'(a) << 25;
        qq  = num / longint'(b);
        rr  = num % longint'(b);
        e   = (int'(ed) >= 384) ? int'(ed) - 512 : int'(ed);
        if (qq >= (longint'(1) << 25)) begin
            frac = (qq >> 2) & 64'h7F_FFFF;
            g    = qq[1];
            st   = qq[0] || (rr != 0);
        end else begin
            frac = (qq >> 1) & 64'h7F_FFFF;
            g    = qq[0];
            st   = (rr != 0);
            e    = e - 1;
        end
        if (rne && g && (st || frac[0])) frac = frac + 1;
        if (frac == (longint'(1) << 23)) begin
            frac = 0;
            e    = e + 1;
        end
        if (e >= 255) begin
            res = {s, 8'hFF, 23'd0};
            flg = 3'b100;
        end else if (e <= 0) begin
            res = {s, 31'd0};
            flg = 3'b010;
        end else begin
            res = {s, 8'(e), frac[22:0]};
            flg = 3'b000;
        end
    endfunction

    // Issue one operation, check latency, result/flags on both instances,
    // hold out_ready low for 'hold' cycles while offering junk input, then
    // complete the handshake.
    task automatic run_op(input logic s, input logic [8:0] ed,
                          input logic [23:0] a, input logic [23:0] b,
                          input int hold, input string tag);
        logic [31:0] er_n, er_t;
        logic [2:0]  ef_n, ef_t;
        int          lat;
        model(s, ed, a, b, 1'b1, er_n, ef_n);
        model(s, ed, a, b, 1'b0, er_t, ef_t);
        @(negedge clk);
        lat = 0;
        while (!in_ready_n && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " in_ready"}, 32'(in_ready_n), 32'd1);
        sign = s; exp_diff = ed; mant_a = a; mant_b = b; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        sign = ~s; exp_diff = ~ed; mant_a = ~a; mant_b = ~b;
        lat = 0;
        while (!out_valid_n && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd27);
        check({tag, " res_rne"}, result_n, er_n);
        check({tag, " flg_rne"}, 32'({ovf_n, unf_n, inv_n}), 32'(ef_n));
        check({tag, " res_trn"}, result_t, er_t);
        check({tag, " flg_trn"}, 32'({ovf_t, unf_t, inv_t}), 32'(ef_t));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            mant_a   = 24'(32'h80_0000 | $urandom_range(0, 32'h7F_FFFF));
            @(negedge clk);
            check({tag, " hold_valid"}, 32'({out_valid_n, in_ready_n}), 32'b10);
            check({tag, " hold_res"}, result_n, er_n);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " post_hs"}, 32'({out_valid_n, in_ready_n, out_valid_t, in_ready_t}), 32'b0101);
    endtask

    initial begin
        logic [8:0]  ed;
        logic [23:0] a, b;
        n_vec = 0; n_err = 0;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sign = 1'b0; exp_diff = 9'd0; mant_a = 24'd0; mant_b = 24'd0;
        #1;
        check("rst_out", {result_n[31:4], out_valid_n, ovf_n, unf_n, inv_n} | result_n, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'({in_ready_n, out_valid_n}), 32'b10);

        run_op(1'b0, 9'd128, 24'hC0_0000, 24'h80_0000, 0, "t1");
        check("t1_const", result_n, 32'h4040_0000);
        run_op(1'b0, 9'd126, 24'h80_0000, 24'hC0_0000, 0, "t2");
        check("t2_rne", result_n, 32'h3EAA_AAAB);
        check("t2_trn", result_t, 32'h3EAA_AAAA);
        run_op(1'b1, 9'd300, 24'h80_0000, 24'h80_0000, 0, "t3");
        check("t3_const", {result_n[31:1], ovf_n}, {31'h7FC0_0000, 1'b1});
        run_op(1'b0, 9'd400, 24'h80_0000, 24'h80_0000, 0, "t4u");
        check("t4u_const", {result_n[31:1], unf_n}, 32'd1);
        run_op(1'b1, 9'd55, 24'hA5_5555, 24'h00_0000, 0, "t4i");
        check("t4i_const", {result_n[31:1], inv_n}, {31'h3FE0_0000, 1'b1});
        run_op(1'b0, 9'd128, 24'hC0_0000, 24'h80_0000, 10, "t5");

        // Reset in the middle of the divide iterations.
        @(negedge clk);
        sign = 1'b0; exp_diff = 9'd128; mant_a = 24'hC0_0000; mant_b = 24'h80_0000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_rst", {result_n[31:3], ovf_n, unf_n, inv_n} | 32'(out_valid_n) | result_n, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_ready", 32'(in_ready_n), 32'd1);
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (out_valid_n) check("t6_spurious", 32'(out_valid_n), 32'd0);
        end
        run_op(1'b0, 9'd128, 24'hC0_0000, 24'h80_0000, 0, "t6");
        check("t6_const", result_n, 32'h4040_0000);

        // Randomized operations.
        for (int k = 0; k < 60; k++) begin
            ed = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 511))
                                             : 9'($urandom_range(100, 160));
            a  = 24'(32'h80_0000 | $urandom_range(0, 32'h7F_FFFF));
            b  = ($urandom_range(0, 15) == 0) ? 24'd0
                                              : 24'(32'h80_0000 | $urandom_range(0, 32'h7F_FFFF));
            if (k < 4) ed = (k[0]) ? 9'd254 : 9'd1;
            run_op(1'($urandom_range(0, 1)), ed, a, b, $urandom_range(0, 3), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
